soc_dma_initiator: RTL and testbench
====================================

Name: soc_dma_initiator

Overview:
- Word-copy DMA engine that acts as a bus initiator on the SoC native memory bus, the same valid/ready bus the CPU drives toward RAM and the TPU.
- The CPU configures it through an MMIO responder port with the same signal set as the TPU MMIO port.
- Once started, it copies LEN 32-bit words from SRC to DST, one read beat then one write beat per word.
- It reports busy, done and error, and drives an interrupt line.

Parameters:
- TIMEOUT_CYCLES, 1024, maximum cycles mem_valid may wait for mem_ready before the beat is abandoned; must be ≥ 1.
- LEN_W, 16, width of the LEN and REMAIN registers in words.

Ports:
- clk  in  1  clock.
- resetn  in  1  asynchronous active-low reset.
- mmio_wr  in  1  register write request, held until mmio_ready.
- mmio_rd  in  1  register read request, held until mmio_ready.
- mmio_addr  in  16  byte offset.
- mmio_wdata  in  32  write data.
- mmio_wstrb  in  4  byte strobes; register writes require 4'hF, any other value is ignored but still acknowledged.
- mmio_rdata  out  32  read data, valid while mmio_ready=1.
- mmio_ready  out  1  one-cycle acknowledge.
- mem_valid  out  1  bus request.
- mem_addr  out  32  word-aligned bus address.
- mem_wdata  out  32  write data.
- mem_wstrb  out  4  4'hF on writes, 4'h0 on reads.
- mem_ready  in  1  bus acknowledge.
- mem_rdata  in  32  read data, sampled when mem_ready=1.
- irq  out  1  level interrupt, equal to STATUS.done & CTRL.irq_en.

Behaviour:

Reset (resetn=0, asynchronous):
- All outputs 0.
- SRC, DST, LEN, REMAIN, data buffer and timeout counter cleared to 0.
- FSM forced to IDLE. A transfer in progress is dropped mid-beat with no completion.

Register map (offsets, RW unless noted):
- 0x00 SRC: bits[1:0] read as 0.
- 0x04 DST: bits[1:0] read as 0.
- 0x08 LEN: words to copy.
- 0x0C CTRL:
  - bit0 start: write-1 pulse, reads 0.
  - bit1 irq_en.
- 0x10 STATUS:
  - bit0 busy (RO).
  - bit1 done (W1C).
  - bit2 error (W1C).
- 0x14 REMAIN (RO).
- Unmapped offsets read 0; writes to them are ignored.

MMIO handshake:
- A request is accepted when (mmio_wr|mmio_rd) && !mmio_ready.
- mmio_ready pulses exactly one cycle later, with mmio_rdata registered in that same cycle.
- A request held high through the ack cycle is not re-accepted.
- Writes to SRC, DST and LEN while busy=1 are ignored but acknowledged.
- start while busy is ignored.

Start (busy=0):
- Copies SRC and DST into working address counters and LEN into REMAIN.
- Clears done and error.
- If LEN=0: done=1 on the next cycle, no bus traffic.
- Otherwise busy=1 and the FSM enters READ.

FSM states: IDLE, READ, WRITE.
- READ:
  - Drives mem_valid=1, mem_addr=rd_ptr, mem_wstrb=0.
  - On mem_ready=1: latch mem_rdata, rd_ptr += 4, go to WRITE.
- WRITE:
  - Drives mem_valid=1, mem_addr=wr_ptr, mem_wdata=buffer, mem_wstrb=4'hF.
  - On mem_ready=1: wr_ptr += 4, REMAIN -= 1.
  - If the new REMAIN is 0, go to IDLE with busy=0 and done=1. Otherwise go to READ.
- All bus outputs are registered.
- While mem_valid=1, addr/wdata/wstrb are held stable until mem_ready is sampled high.
- mem_valid drops for at least one cycle between beats, so at most one beat per two cycles.
- mem_ready while mem_valid=0 is ignored.
- Address counters wrap modulo 2^32.

Timeout:
- The counter resets at each beat start.
- If mem_valid has been high for TIMEOUT_CYCLES cycles with no mem_ready:
  - mem_valid drops.
  - error=1, done=1, busy=0.
  - FSM returns to IDLE.
  - REMAIN keeps the count of words not yet written.

Simultaneous events:
- A W1C write to done in the same cycle as completion sets done; set wins.
- An MMIO read of STATUS in the completion cycle returns the pre-update value.

irq: combinational from registered bits; no glitches from mmio traffic.

Test Plan:
- Reset with resetn=0 asynchronously mid-READ (mem_valid=1) -> mem_valid, irq and mmio_ready go to 0 immediately, all registers read 0 after release.
- SRC=0x100, DST=0x200, LEN=3, RAM at 0x100..0x108 = 0xA1,0xB2,0xC3, zero-wait ready -> exactly 6 beats in the order R100,W200,R104,W204,R108,W208. Words at 0x200..0x208 match. STATUS=0x2, REMAIN=0.
- Same transfer with mem_ready delayed 3 cycles per beat, irq_en=1 -> addr/wdata held stable during the wait, irq rises on completion, W1C 0x2 to STATUS drops irq.
- LEN=0, start -> no mem_valid, done=1 one cycle later.
- TIMEOUT_CYCLES=8, LEN=2, first write never acknowledged -> mem_valid drops after 8 cycles, STATUS=0x6, REMAIN=2.
- While busy: write SRC=0xDEAD0000 and start=1 -> SRC is unchanged, the transfer proceeds normally, and every mmio access is acknowledged within one cycle.

Source files
------------

// File: rtl/soc_dma_initiator.sv
// soc_dma_initiator: word-copy DMA engine, initiator on the SoC native memory bus.
//   Configured through an MMIO responder port (SRC/DST/LEN/CTRL/STATUS/REMAIN).
//   Once started it copies LEN 32-bit words SRC->DST, one read beat then one
//   write beat per word, with a per-beat acknowledge timeout.
// Ports:
//   clk, resetn             clock, async active-low reset
//   mmio_wr/rd/addr/wdata/wstrb -> mmio_rdata/mmio_ready   register access
//   mem_valid/addr/wdata/wstrb  <- mem_ready/mem_rdata     bus initiator
//   irq                     level interrupt = done & irq_en
module soc_dma_initiator #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int LEN_W          = 16
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mmio_wr,
  input  logic        mmio_rd,
  input  logic [15:0] mmio_addr,
  input  logic [31:0] mmio_wdata,
  input  logic [3:0]  mmio_wstrb,
  output logic [31:0] mmio_rdata,
  output logic        mmio_ready,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        irq
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [15:0] A_SRC    = 16'h0000;
  localparam logic [15:0] A_DST    = 16'h0004;
  localparam logic [15:0] A_LEN    = 16'h0008;
  localparam logic [15:0] A_CTRL   = 16'h000C;
  localparam logic [15:0] A_STATUS = 16'h0010;
  localparam logic [15:0] A_REMAIN = 16'h0014;

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t             state_q, state_d;
  logic [31:2]        src_q, dst_q;
  logic [LEN_W-1:0]   len_q, remain_q;
  logic               irq_en_q, done_q, err_q;
  logic [31:0]        rd_ptr, wr_ptr, data_q;
  logic [TW-1:0]      tcnt;
  logic [31:0]        rd_val;

  logic acc, wr_ok, busy, start_go, w1c_done, w1c_err;
  logic beat_done, tmo, done_set, err_set;

  // A request held through its ack cycle must not be taken twice, hence the
  // !mmio_ready qualifier.
  assign acc       = (mmio_wr | mmio_rd) & ~mmio_ready;
  assign wr_ok     = acc & mmio_wr & (mmio_wstrb == 4'hF);
  assign busy      = (state_q != IDLE);
  assign start_go  = wr_ok & (mmio_addr == A_CTRL) & mmio_wdata[0] & ~busy;
  assign w1c_done  = wr_ok & (mmio_addr == A_STATUS) & mmio_wdata[1];
  assign w1c_err   = wr_ok & (mmio_addr == A_STATUS) & mmio_wdata[2];
  assign beat_done = mem_valid & mem_ready;
  assign tmo       = mem_valid & ~mem_ready & (tcnt == TW'(TIMEOUT_CYCLES - 1));
  assign irq       = done_q & irq_en_q;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    done_set = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: if (start_go) begin
        if (len_q == '0) done_set = 1'b1;
        else             state_d  = READ;
      end
      READ: begin
        if (beat_done) state_d = WRITE;
        else if (tmo) begin
          state_d = IDLE; done_set = 1'b1; err_set = 1'b1;
        end
      end
      WRITE: begin
        if (beat_done) begin
          if (remain_q == LEN_W'(1)) begin
            state_d = IDLE; done_set = 1'b1;
          end else state_d = READ;
        end else if (tmo) begin
          state_d = IDLE; done_set = 1'b1; err_set = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- bus datapath ----------------
  // A beat is raised only from a cycle where mem_valid is low, which gives the
  // mandatory idle cycle between beats and keeps addr/wdata/wstrb frozen until
  // the handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mem_valid <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      data_q    <= '0;
      remain_q  <= '0;
      tcnt      <= '0;
    end else if (state_q == IDLE) begin
      mem_valid <= 1'b0;
      if (start_go) begin
        rd_ptr   <= {src_q, 2'b00};
        wr_ptr   <= {dst_q, 2'b00};
        remain_q <= len_q;
      end
    end else if (!mem_valid) begin
      mem_valid <= 1'b1;
      tcnt      <= '0;
      if (state_q == READ) begin
        mem_addr  <= rd_ptr;
        mem_wdata <= '0;
        mem_wstrb <= 4'h0;
      end else begin
        mem_addr  <= wr_ptr;
        mem_wdata <= data_q;
        mem_wstrb <= 4'hF;
      end
    end else if (beat_done) begin
      mem_valid <= 1'b0;
      if (state_q == READ) begin
        data_q <= mem_rdata;
        rd_ptr <= rd_ptr + 32'd4;
      end else begin
        wr_ptr   <= wr_ptr + 32'd4;
        remain_q <= remain_q - LEN_W'(1);
      end
    end else if (tmo) begin
      mem_valid <= 1'b0;
    end else begin
      tcnt <= tcnt + TW'(1);
    end
  end

  // ---------------- registers ----------------
  always_comb begin
    rd_val = '0;
    case (mmio_addr)
      A_SRC:    rd_val = {src_q, 2'b00};
      A_DST:    rd_val = {dst_q, 2'b00};
      A_LEN:    rd_val = 32'(len_q);
      A_CTRL:   rd_val = {30'b0, irq_en_q, 1'b0};
      A_STATUS: rd_val = {29'b0, err_q, done_q, busy};
      A_REMAIN: rd_val = 32'(remain_q);
      default:  rd_val = '0;
    endcase
  end

  // rdata is captured from pre-update state, so a STATUS read landing in the
  // completion cycle returns the old value. Set beats W1C on done/error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      mmio_ready <= 1'b0;
      mmio_rdata <= '0;
      src_q      <= '0;
      dst_q      <= '0;
      len_q      <= '0;
      irq_en_q   <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      mmio_ready <= acc;
      mmio_rdata <= (acc & mmio_rd) ? rd_val : 32'd0;
      if (wr_ok && !busy) begin
        if (mmio_addr == A_SRC) src_q <= mmio_wdata[31:2];
        if (mmio_addr == A_DST) dst_q <= mmio_wdata[31:2];
        if (mmio_addr == A_LEN) len_q <= mmio_wdata[LEN_W-1:0];
      end
      if (wr_ok && mmio_addr == A_CTRL) irq_en_q <= mmio_wdata[1];
      if (start_go) begin
        done_q <= done_set;
        err_q  <= 1'b0;
      end else begin
        done_q <= done_set | (done_q & ~w1c_done);
        err_q  <= err_set  | (err_q  & ~w1c_err);
      end
    end
  end

endmodule

// File: tb/tb_soc_dma_initiator.sv
module tb_soc_dma_initiator;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        mmio_wr = 1'b0, mmio_rd = 1'b0;
  logic [15:0] mmio_addr = '0;
  logic [31:0] mmio_wdata = '0;
  logic [3:0]  mmio_wstrb = '0;
  logic [31:0] mmio_rdata;
  logic        mmio_ready;
  logic        mem_valid;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        irq;

  soc_dma_initiator #(.TIMEOUT_CYCLES(8), .LEN_W(16)) dut (
    .clk(clk), .resetn(resetn),
    .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_wstrb(mmio_wstrb),
    .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } beat_t;

  beat_t exp_q[$];
  beat_t obs_q[$];

  logic [31:0] ram [0:1023];
  int checks = 0, errors = 0;
  int mem_delay = 0;
  bit hang_wr = 0;
  int wcnt = 0, vrun = 0, last_run = 0, vtotal = 0, stab_err = 0;
  int mmio_to = 0, last_lat = 0;
  logic [31:0] s_addr = '0, s_wdata = '0;
  logic [3:0]  s_strb = '0;

  // Memory responder / beat monitor, evaluated on the falling edge so it
  // sees settled DUT outputs and drives mem_ready for the next rising edge.
  always @(negedge clk) begin
    beat_t o;
    if (!resetn) begin
      mem_ready = 1'b0; wcnt = 0; vrun = 0;
    end else begin
      if (mem_valid) begin vrun++; vtotal++; end
      else if (vrun > 0) begin last_run = vrun; vrun = 0; end
      if (mem_ready) begin
        o.addr = s_addr; o.data = s_wdata; o.strb = s_strb;
        obs_q.push_back(o);
        if (s_strb == 4'hF) ram[s_addr[11:2]] = s_wdata;
        mem_ready = 1'b0; wcnt = 0;
      end else if (mem_valid) begin
        if (wcnt > 0 && (mem_addr !== s_addr || mem_wdata !== s_wdata || mem_wstrb !== s_strb))
          stab_err++;
        s_addr = mem_addr; s_wdata = mem_wdata; s_strb = mem_wstrb;
        if (!(hang_wr && mem_wstrb == 4'hF) && wcnt >= mem_delay) begin
          mem_ready = 1'b1;
          mem_rdata = ram[mem_addr[11:2]];
        end else wcnt++;
      end else wcnt = 0;
    end
  end

  task automatic mmio_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    mmio_addr = a; mmio_wdata = d; mmio_wstrb = s; mmio_wr = 1'b1;
    last_lat = 0;
    do begin @(negedge clk); last_lat++; end while (!mmio_ready && last_lat < 8);
    if (!mmio_ready) mmio_to++;
    mmio_wr = 1'b0;
  endtask

  task automatic mmio_read(input logic [15:0] a, output logic [31:0] d);
    @(negedge clk);
    mmio_addr = a; mmio_rd = 1'b1;
    last_lat = 0;
    do begin @(negedge clk); last_lat++; end while (!mmio_ready && last_lat < 8);
    if (!mmio_ready) mmio_to++;
    d = mmio_rdata;
    mmio_rd = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    logic [31:0] r;
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      mmio_read(16'h10, r);
      if (r[0] == 1'b0) begin ok = 1; break; end
    end
  endtask

  // Expected beat sequence of a copy, taken from the model RAM contents.
  task automatic push_copy(input logic [31:0] src, input logic [31:0] dst, input int n);
    beat_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = src + 32'(4 * i); e.data = '0; e.strb = 4'h0; exp_q.push_back(e);
      e.addr = dst + 32'(4 * i); e.data = ram[e.addr[11:2] - 10'(dst[11:2]) + 10'(src[11:2])];
      e.strb = 4'hF; exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    logic [31:0] r;
    repeat (2) @(negedge clk);
    checks++; if ({mem_valid, mmio_ready, irq, mem_wstrb} !== 7'b0 || mem_addr !== 32'd0 || mmio_rdata !== 32'd0) begin
      errors++; $display("FAIL reset_outputs got valid=%b ready=%b irq=%b addr=%h exp all 0", mem_valid, mmio_ready, irq, mem_addr);
    end
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mmio_read(16'(i * 4), r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL reset_reg_%0h got %h exp 0", i * 4, r); end
    end
  endtask

  task automatic test_regs();
    logic [31:0] r;
    mmio_write(16'h00, 32'h0000_0103, 4'hF);
    mmio_read(16'h00, r);
    checks++; if (r !== 32'h100) begin errors++; $display("FAIL src_align got %h exp %h", r, 32'h100); end
    mmio_write(16'h00, 32'h0000_FFFF, 4'h3);
    mmio_read(16'h00, r);
    checks++; if (r !== 32'h100) begin errors++; $display("FAIL partial_strobe got %h exp %h", r, 32'h100); end
    mmio_write(16'h20, 32'hFFFF_FFFF, 4'hF);
    mmio_read(16'h20, r);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL unmapped got %h exp 0", r); end
    mmio_write(16'h0C, 32'h2, 4'hF);
    mmio_read(16'h0C, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL ctrl_rb got %h exp 2", r); end
    mmio_write(16'h0C, 32'h0, 4'hF);
  endtask

  task automatic test_copy();
    logic [31:0] r; bit ok; beat_t e, o;
    ram[64] = 32'hA1; ram[65] = 32'hB2; ram[66] = 32'hC3;
    ram[128] = 0; ram[129] = 0; ram[130] = 0;
    mem_delay = 0; exp_q.delete(); obs_q.delete();
    mmio_write(16'h00, 32'h100, 4'hF);
    mmio_write(16'h04, 32'h200, 4'hF);
    mmio_write(16'h08, 32'd3, 4'hF);
    push_copy(32'h100, 32'h200, 3);
    mmio_write(16'h0C, 32'h1, 4'hF);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL copy_idle got busy exp idle"); end
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL copy_beats got %0d exp 6", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.addr !== e.addr || o.strb !== e.strb || (e.strb == 4'hF && o.data !== e.data)) begin
        errors++; $display("FAIL copy_beat got %h/%h/%h exp %h/%h/%h", o.addr, o.strb, o.data, e.addr, e.strb, e.data);
      end
    end
    checks++; if (ram[128] !== 32'hA1 || ram[129] !== 32'hB2 || ram[130] !== 32'hC3) begin
      errors++; $display("FAIL copy_ram got %h %h %h exp a1 b2 c3", ram[128], ram[129], ram[130]);
    end
    mmio_read(16'h10, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL copy_status got %h exp 2", r); end
    mmio_read(16'h14, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL copy_remain got %h exp 0", r); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL copy_irq got %b exp 0", irq); end
  endtask

  task automatic test_wait_irq();
    logic [31:0] r; bit ok; beat_t e, o;
    ram[64] = 32'h1111; ram[65] = 32'h2222; ram[66] = 32'h3333;
    ram[192] = 0; ram[193] = 0; ram[194] = 0;
    mem_delay = 3; stab_err = 0; exp_q.delete(); obs_q.delete();
    mmio_write(16'h04, 32'h300, 4'hF);
    push_copy(32'h100, 32'h300, 3);
    mmio_write(16'h0C, 32'h3, 4'hF);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wait_irq_start got %b exp 0", irq); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL wait_idle got busy exp idle"); end
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL wait_irq_done got %b exp 1", irq); end
    checks++; if (stab_err != 0) begin errors++; $display("FAIL wait_stable got %0d exp 0", stab_err); end
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL wait_beats got %0d exp 6", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.addr !== e.addr || o.strb !== e.strb || (e.strb == 4'hF && o.data !== e.data)) begin
        errors++; $display("FAIL wait_beat got %h/%h/%h exp %h/%h/%h", o.addr, o.strb, o.data, e.addr, e.strb, e.data);
      end
    end
    mmio_write(16'h10, 32'h2, 4'hF);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL wait_w1c_irq got %b exp 0", irq); end
    mmio_read(16'h10, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL wait_w1c_status got %h exp 0", r); end
  endtask

  task automatic test_len0();
    logic [31:0] r; int v0;
    v0 = vtotal;
    mmio_write(16'h08, 32'd0, 4'hF);
    mmio_write(16'h0C, 32'h3, 4'hF);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL len0_done_next got irq=%b exp 1", irq); end
    repeat (4) @(negedge clk);
    checks++; if (vtotal != v0) begin errors++; $display("FAIL len0_no_bus got %0d valid cycles exp 0", vtotal - v0); end
    mmio_read(16'h10, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL len0_status got %h exp 2", r); end
    mmio_write(16'h10, 32'h2, 4'hF);
    mmio_write(16'h0C, 32'h0, 4'hF);
  endtask

  task automatic test_timeout();
    logic [31:0] r; bit ok;
    mem_delay = 0; hang_wr = 1; ram[256] = 32'h0;
    exp_q.delete(); obs_q.delete();
    mmio_write(16'h04, 32'h400, 4'hF);
    mmio_write(16'h08, 32'd2, 4'hF);
    mmio_write(16'h0C, 32'h1, 4'hF);
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL tmo_idle got busy exp idle"); end
    checks++; if (last_run != 8) begin errors++; $display("FAIL tmo_len got %0d exp 8", last_run); end
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL tmo_beats got %0d exp 1", obs_q.size()); end
    mmio_read(16'h10, r);
    checks++; if (r !== 32'h6) begin errors++; $display("FAIL tmo_status got %h exp 6", r); end
    mmio_read(16'h14, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL tmo_remain got %h exp 2", r); end
    checks++; if (ram[256] !== 32'h0) begin errors++; $display("FAIL tmo_ram got %h exp 0", ram[256]); end
    hang_wr = 0;
    mmio_write(16'h10, 32'h6, 4'hF);
    mmio_read(16'h10, r);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL tmo_w1c got %h exp 0", r); end
    obs_q.delete();
  endtask

  task automatic test_busy();
    logic [31:0] r; bit ok; beat_t e, o;
    ram[64] = 32'h5A5A_0001; ram[65] = 32'h5A5A_0002; ram[66] = 32'h5A5A_0003;
    mem_delay = 3; exp_q.delete(); obs_q.delete();
    mmio_write(16'h00, 32'h100, 4'hF);
    mmio_write(16'h04, 32'h500, 4'hF);
    mmio_write(16'h08, 32'd3, 4'hF);
    push_copy(32'h100, 32'h500, 3);
    mmio_write(16'h0C, 32'h1, 4'hF);
    mmio_write(16'h00, 32'hDEAD_0000, 4'hF);
    checks++; if (last_lat != 1) begin errors++; $display("FAIL busy_ack_src got %0d exp 1", last_lat); end
    mmio_write(16'h08, 32'd7, 4'hF);
    mmio_write(16'h0C, 32'h1, 4'hF);
    checks++; if (last_lat != 1) begin errors++; $display("FAIL busy_ack_start got %0d exp 1", last_lat); end
    mmio_read(16'h00, r);
    checks++; if (r !== 32'h100 || last_lat != 1) begin errors++; $display("FAIL busy_src got %h lat %0d exp 100 lat 1", r, last_lat); end
    wait_idle(ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_idle got busy exp idle"); end
    checks++; if (obs_q.size() != 6) begin errors++; $display("FAIL busy_beats got %0d exp 6", obs_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      checks++; if (o.addr !== e.addr || o.strb !== e.strb || (e.strb == 4'hF && o.data !== e.data)) begin
        errors++; $display("FAIL busy_beat got %h/%h/%h exp %h/%h/%h", o.addr, o.strb, o.data, e.addr, e.strb, e.data);
      end
    end
    mmio_read(16'h08, r);
    checks++; if (r !== 32'd3) begin errors++; $display("FAIL busy_len got %h exp 3", r); end
    mmio_read(16'h10, r);
    checks++; if (r !== 32'h2) begin errors++; $display("FAIL busy_status got %h exp 2", r); end
    checks++; if (mmio_to != 0) begin errors++; $display("FAIL mmio_ack_timeouts got %0d exp 0", mmio_to); end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] r; int n;
    mem_delay = 6; exp_q.delete(); obs_q.delete();
    mmio_write(16'h04, 32'h600, 4'hF);
    mmio_write(16'h0C, 32'h1, 4'hF);
    n = 0;
    while (!mem_valid && n < 10) begin @(negedge clk); n++; end
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL mid_valid got %b exp 1", mem_valid); end
    mmio_addr = 16'h10; mmio_rd = 1'b1;
    @(negedge clk);
    checks++; if (mmio_ready !== 1'b1 || mem_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre got ready=%b valid=%b exp 1 1", mmio_ready, mem_valid);
    end
    #2 resetn = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || mmio_ready !== 1'b0 || irq !== 1'b0) begin
      errors++; $display("FAIL mid_async got valid=%b ready=%b irq=%b exp 0 0 0", mem_valid, mmio_ready, irq);
    end
    mmio_rd = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mmio_read(16'(i * 4), r);
      checks++; if (r !== 32'd0) begin errors++; $display("FAIL mid_reg_%0h got %h exp 0", i * 4, r); end
    end
    repeat (4) @(negedge clk);
    checks++; if (obs_q.size() != 0 || mem_valid !== 1'b0) begin
      errors++; $display("FAIL mid_no_beat got %0d beats valid=%b exp 0 0", obs_q.size(), mem_valid);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 32'h0;
    test_reset();
    test_regs();
    test_copy();
    test_wait_irq();
    test_len0();
    test_timeout();
    test_busy();
    test_reset_mid_read();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
